iir_biquad_cascade: RTL

Parametrised cascade of N_SEC second-order IIR sections (direct form I) on signed W-bit audio samples. It replaces fixed first-order high-pass/low-pass chains with runtime-loadable coefficients. A single time-multiplexed multiply-accumulate unit computes every section. Sits in the audio datapath and takes one sample per Enable strobe.

---
 rtl/iir_pkg.sv | 31 +++
 rtl/iir_biquad_cascade_if.sv | 29 ++
 rtl/iir_mac_sat.sv | 58 +++++
 rtl/iir_biquad_cascade.sv | 129 ++++++++++++
 4 files changed

// File: rtl/iir_pkg.sv
// rtl/iir_pkg.sv - shared constants, state type and helpers for the biquad cascade
// Purpose: coefficient slot indices, controller states, accumulator sizing and
//          the passthrough b0 value used at reset.
// Ports:   none (package)
package iir_pkg;

  // Position of each coefficient inside a section's group of five.
  localparam logic [2:0] K_B0 = 3'd0;
  localparam logic [2:0] K_B1 = 3'd1;
  localparam logic [2:0] K_B2 = 3'd2;
  localparam logic [2:0] K_A1 = 3'd3;
  localparam logic [2:0] K_A2 = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    UPD  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Five W x CW products summed; three guard bits keep the sum exact.
  function automatic int acc_w(input int w, input int cw);
    return w + cw + 3;
  endfunction

  // 1.0 in the coefficient format, loaded into every b0 at reset.
  function automatic int pass_b0(input int cfrac);
    return 1 << cfrac;
  endfunction

endpackage

// File: rtl/iir_biquad_cascade_if.sv
// rtl/iir_biquad_cascade_if.sv - sample, coefficient and status signals of the biquad cascade
// Purpose: bundles the sample strobe/data, coefficient write port and result/status.
// Ports:   master drives Enable, u, coef_we, coef_addr, coef_data;
//          slave (the filter) drives y, y_valid, busy, overrun.
interface iir_biquad_cascade_if #(
  parameter int W   = 25,
  parameter int CW  = 18,
  parameter int CAW = 4
);
  logic                 Enable;
  logic signed [W-1:0]  u;
  logic                 coef_we;
  logic [CAW-1:0]       coef_addr;
  logic signed [CW-1:0] coef_data;
  logic signed [W-1:0]  y;
  logic                 y_valid;
  logic                 busy;
  logic                 overrun;

  modport master (
    output Enable, u, coef_we, coef_addr, coef_data,
    input  y, y_valid, busy, overrun
  );

  modport slave (
    input  Enable, u, coef_we, coef_addr, coef_data,
    output y, y_valid, busy, overrun
  );
endinterface

// File: rtl/iir_mac_sat.sv
// rtl/iir_mac_sat.sv - shared multiply-accumulate with floor shift and saturation
// Purpose: one signed product per enabled cycle, added or subtracted into a
//          full-precision accumulator; output is acc >>> CFRAC clamped to W bits.
// Ports:   clk, rst (sync active-high), en (accumulate this cycle),
//          clr (load this product instead of adding), sub (negate product),
//          coef, din (operands), sat (saturated section result).
module iir_mac_sat
  import iir_pkg::*;
#(
  parameter int W     = 25,
  parameter int CW    = 18,
  parameter int CFRAC = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 clr,
  input  logic                 sub,
  input  logic signed [CW-1:0] coef,
  input  logic signed [W-1:0]  din,
  output logic signed [W-1:0]  sat
);
  localparam int AW = acc_w(W, CW);

  logic signed [W+CW-1:0] prod;
  logic signed [AW-1:0]   prod_ext;
  logic signed [AW-1:0]   term;
  logic signed [AW-1:0]   acc;
  logic signed [AW-1:0]   shifted;
  logic [AW-W:0]          hi;
  logic                   in_range;

  assign prod     = coef * din;
  assign prod_ext = {{(AW-W-CW){prod[W+CW-1]}}, prod};
  assign term     = sub ? -prod_ext : prod_ext;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (en) begin
      acc <= clr ? term : acc + term;
    end
  end

  // Arithmetic shift gives floor rounding; the value fits in W bits only
  // when every bit from the W-bit sign position upward agrees.
  assign shifted  = acc >>> CFRAC;
  assign hi       = shifted[AW-1:W-1];
  assign in_range = (&hi) | ~(|hi);

  always_comb begin
    sat = shifted[W-1:0];
    if (!in_range) begin
      sat = shifted[AW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/iir_biquad_cascade.sv
// rtl/iir_biquad_cascade.sv - N_SEC direct-form-I biquads sharing one MAC
// Purpose: per Enable strobe, runs the sample through every section in turn
//          (5 MAC cycles + 1 update cycle each), then presents y with y_valid.
// Ports:   CLK, Reset (sync active-high), io (slave side of the cascade interface:
//          Enable/u in, coef_we/coef_addr/coef_data in, y/y_valid/busy/overrun out).
module iir_biquad_cascade
  import iir_pkg::*;
#(
  parameter int W     = 25,
  parameter int CW    = 18,
  parameter int CFRAC = 16,
  parameter int N_SEC = 2
) (
  input  logic CLK,
  input  logic Reset,
  iir_biquad_cascade_if.slave io
);
  localparam int NCOEF = 5 * N_SEC;
  localparam int CAW   = $clog2(NCOEF);
  localparam int SW    = (N_SEC > 1) ? $clog2(N_SEC) : 1;

  state_t               state, state_nx;
  logic [2:0]           k;
  logic [SW-1:0]        sec;
  logic signed [W-1:0]  xin;
  logic signed [W-1:0]  x1 [N_SEC];
  logic signed [W-1:0]  x2 [N_SEC];
  logic signed [W-1:0]  y1 [N_SEC];
  logic signed [W-1:0]  y2 [N_SEC];
  logic signed [CW-1:0] coef [NCOEF];

  logic [CAW-1:0]       cidx;
  logic signed [W-1:0]  operand;
  logic signed [W-1:0]  sat;
  logic                 sub;
  logic                 last_sec;

  assign last_sec = (sec == SW'(N_SEC - 1));
  assign cidx     = CAW'(5 * int'(sec) + int'(k));

  always_comb begin
    operand = xin;
    sub     = 1'b0;
    case (k)
      K_B0:    operand = xin;
      K_B1:    operand = x1[sec];
      K_B2:    operand = x2[sec];
      K_A1:    begin operand = y1[sec]; sub = 1'b1; end
      default: begin operand = y2[sec]; sub = 1'b1; end
    endcase
  end

  iir_mac_sat #(.W(W), .CW(CW), .CFRAC(CFRAC)) u_mac (
    .clk  (CLK),
    .rst  (Reset),
    .en   (state == MAC),
    .clr  (k == K_B0),
    .sub  (sub),
    .coef (coef[cidx]),
    .din  (operand),
    .sat  (sat)
  );

  always_ff @(posedge CLK) begin
    if (Reset) state <= IDLE;
    else       state <= state_nx;
  end

  // DONE is still reported busy so an Enable landing there is flagged.
  always_comb begin
    state_nx   = state;
    io.busy    = (state != IDLE);
    io.y_valid = (state == DONE);
    case (state)
      IDLE:    if (io.Enable) state_nx = MAC;
      MAC:     if (k == K_A2) state_nx = UPD;
      UPD:     state_nx = last_sec ? DONE : MAC;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      k          <= '0;
      sec        <= '0;
      xin        <= '0;
      io.y       <= '0;
      io.overrun <= 1'b0;
      for (int s = 0; s < N_SEC; s++) begin
        x1[s] <= '0;
        x2[s] <= '0;
        y1[s] <= '0;
        y2[s] <= '0;
      end
      for (int i = 0; i < NCOEF; i++) begin
        coef[i] <= (i % 5 == 0) ? CW'(pass_b0(CFRAC)) : '0;
      end
    end else begin
      io.overrun <= io.Enable && (state != IDLE);
      case (state)
        IDLE: begin
          if (io.Enable) begin
            xin <= io.u;
            sec <= '0;
            k   <= K_B0;
          end else if (io.coef_we && (io.coef_addr < CAW'(NCOEF))) begin
            coef[io.coef_addr] <= io.coef_data;
          end
        end
        MAC: begin
          k <= k + 3'd1;
        end
        UPD: begin
          x2[sec] <= x1[sec];
          x1[sec] <= xin;
          y2[sec] <= y1[sec];
          y1[sec] <= sat;
          xin     <= sat;
          k       <= K_B0;
          // y is loaded here so it is already valid in the DONE cycle.
          if (last_sec) io.y <= sat;
          else          sec  <= sec + SW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
